plru_tree_tracker: RTL and testbench

//  Sequential tree-PLRU replacement-state store for the last-level cache.

---
 rtl/plru_tree_tracker.sv | 153 +++++++++++++++
 tb/tb_plru_tree_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/plru_tree_tracker.sv
// plru_tree_tracker: tree-PLRU replacement state, one (NUM_WAYS-1)-bit tree
// per set, one request per cycle (TOUCH / FILL / QUERY / INVAL).
// Optional macro PLRU_TRACE_EN: prints every RUN-mode tree write in simulation.
module plru_tree_tracker #(
  parameter int NUM_SETS = 16384,
  parameter int NUM_WAYS = 8,
  localparam int SET_W  = $clog2(NUM_SETS),
  localparam int WAY_W  = $clog2(NUM_WAYS),
  localparam int TREE_W = NUM_WAYS - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [WAY_W-1:0] req_way,
  output logic             rsp_valid,
  output logic [WAY_W-1:0] rsp_way,
  output logic             busy
);

  localparam logic [1:0] OP_TOUCH = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_QUERY = 2'b10;
  localparam logic [1:0] OP_INVAL = 2'b11;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            r_state;
  logic [SET_W-1:0]  r_cnt;
  logic              r_ready;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [WAY_W-1:0]  r_rsp_way;
  logic [TREE_W-1:0] r_tree [NUM_SETS];

  logic              w_accept;
  logic              w_run_wr;
  logic              w_init_wr;
  logic [TREE_W-1:0] w_tree_cur;
  logic [TREE_W-1:0] w_tree_nxt;
  logic [WAY_W-1:0]  w_victim;
  logic [WAY_W-1:0]  w_path_way;
  logic [WAY_W-1:0]  w_rsp_way_d;

  // Walk root->leaf along 'way', writing each visited node with its way bit
  // (inverted when inv=1, which steers the next victim walk onto 'way').
  function automatic logic [TREE_W-1:0] f_path(input logic [TREE_W-1:0] t,
                                               input logic [WAY_W-1:0]  way,
                                               input logic              inv);
    logic [TREE_W-1:0] r;
    logic              b;
    int                n;
    r = t;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = way[WAY_W-1-l];
      for (int k = 0; k < TREE_W; k++)
        if (k == n) r[k] = b ^ inv;
      n = 2 * n + 1 + int'(b);
    end
    return r;
  endfunction

  // Victim walk: at each node follow the child opposite the stored bit.
  function automatic logic [WAY_W-1:0] f_victim(input logic [TREE_W-1:0] t);
    logic [WAY_W-1:0] v;
    logic             b;
    int               n;
    v = '0;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b1;
      for (int k = 0; k < TREE_W; k++)
        if (k == n) b = ~t[k];
      v[WAY_W-1-l] = b;
      n = 2 * n + 1 + int'(b);
    end
    return v;
  endfunction

  // A flush in the same cycle as a handshake cancels that request.
  assign w_accept    = req_valid & r_ready & ~flush;
  assign w_run_wr    = w_accept & (req_op != OP_QUERY);
  assign w_init_wr   = (r_state == S_INIT);
  assign w_tree_cur  = r_tree[req_set];
  assign w_victim    = f_victim(w_tree_cur);
  assign w_path_way  = (req_op == OP_FILL) ? w_victim : req_way;
  assign w_tree_nxt  = f_path(w_tree_cur, w_path_way, req_op == OP_INVAL);
  assign w_rsp_way_d = ((req_op == OP_FILL) || (req_op == OP_QUERY)) ? w_victim : req_way;

  // Control FSM: INIT sweep of NUM_SETS cycles, then RUN; response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_way   <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) r_rsp_way <= w_rsp_way_d;
      if (flush) begin
        r_state <= S_INIT;
        r_cnt   <= '0;
        r_ready <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_INIT: begin
            if (r_cnt == LAST_SET) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Tree storage: no reset; cleared one set per cycle by the INIT sweep.
  always_ff @(posedge clk) begin
    if (w_init_wr)
      r_tree[r_cnt] <= '0;
    else if (w_run_wr)
      r_tree[req_set] <= w_tree_nxt;
  end

`ifdef PLRU_TRACE_EN
  // Simulation trace of every RUN-mode tree update.
  always @(posedge clk) begin
    if (rst_n && w_run_wr && !w_init_wr)
      $display("PLRU set=%0d op=%0d tree=%b", req_set, req_op, w_tree_nxt);
  end
`else
  // Trace disabled: no simulation-only logic is present.
`endif

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_way   = r_rsp_way;

endmodule

// File: tb/tb_plru_tree_tracker.sv
// Testbench for plru_tree_tracker (NUM_SETS=16, NUM_WAYS=8).
module tb_plru_tree_tracker;

  localparam int NS = 16;
  localparam int NW = 8;
  localparam logic [1:0] TOUCH = 2'b00, FILL = 2'b01, QUERY = 2'b10, INVAL = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [3:0] req_set = 4'd0;
  logic [2:0] req_way = 3'd0;
  logic       rsp_valid;
  logic [2:0] rsp_way;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: node bits per set, heap-numbered (root 0, children 2n+1 / 2n+2).
  int mdl [NS][NW-1];

  typedef struct {
    logic [1:0] op;
    int         set;
    int         way;
    int         exp;
  } vec_t;
  vec_t tbl [10];

  plru_tree_tracker #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_set(req_set), .req_way(req_way),
    .rsp_valid(rsp_valid), .rsp_way(rsp_way), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void m_clear();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < NW - 1; k++) mdl[s][k] = 0;
  endfunction

  function automatic int m_victim(int s);
    int n = 0;
    int v = 0;
    for (int l = 0; l < 3; l++) begin
      int b = (mdl[s][n] != 0) ? 0 : 1;
      v = v * 2 + b;
      n = 2 * n + 1 + b;
    end
    return v;
  endfunction

  function automatic void m_mark(int s, int w, int inv);
    int n = 0;
    for (int l = 0; l < 3; l++) begin
      int b = (w >> (2 - l)) & 1;
      mdl[s][n] = (inv != 0) ? 1 - b : b;
      n = 2 * n + 1 + b;
    end
  endfunction

  // Returns expected response way and advances the model.
  function automatic int m_apply(logic [1:0] op, int s, int w);
    int v;
    case (op)
      TOUCH: begin m_mark(s, w, 0); return w; end
      FILL:  begin v = m_victim(s); m_mark(s, v, 0); return v; end
      QUERY: return m_victim(s);
      default: begin m_mark(s, w, 1); return w; end
    endcase
  endfunction

  // Drive one request for a cycle (inputs change at negedge), then check the response.
  task automatic issue(input logic [1:0] op, input int s, input int w, input int exp, input string nm);
    req_valid = 1'b1;
    req_op    = op;
    req_set   = s[3:0];
    req_way   = w[2:0];
    @(negedge clk);
    req_valid = 1'b0;
    check({nm, "_rspvld"}, int'(rsp_valid), 1);
    check(nm, int'(rsp_way), exp);
  endtask

  // Expect n busy cycles (busy=1, ready=0) from the current sample point, then RUN.
  task automatic wait_init(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      check({nm, "_busy"}, int'({busy, req_ready}), 2);
      @(negedge clk);
    end
    check({nm, "_run"}, int'({busy, req_ready}), 1);
  endtask

  initial begin
    tbl[0] = '{QUERY, 3, 0, 7};
    tbl[1] = '{TOUCH, 2, 5, 5};
    tbl[2] = '{QUERY, 2, 0, 3};
    tbl[3] = '{FILL,  4, 0, 7};
    tbl[4] = '{QUERY, 4, 0, 3};
    tbl[5] = '{INVAL, 1, 2, 2};
    tbl[6] = '{QUERY, 1, 0, 2};
    tbl[7] = '{FILL,  2, 6, 3};
    tbl[8] = '{QUERY, 2, 0, 7};
    tbl[9] = '{TOUCH, 7, 3, 3};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", int'(req_ready), 0);
    check("rst_rspvld", int'(rsp_valid), 0);
    check("rst_rspway", int'(rsp_way), 0);
    check("rst_busy", int'(busy), 1);

    rst_n = 1'b1;
    wait_init(NS, "init");

    // Directed table, applied back-to-back
    for (int i = 0; i < 10; i++)
      issue(tbl[i].op, tbl[i].set, tbl[i].way, tbl[i].exp, $sformatf("tbl%0d", i));
    @(negedge clk);
    check("idle_rspvld", int'(rsp_valid), 0);
    check("tree_set4", int'(dut.r_tree[4]), int'(7'b100_0101));
    check("tree_set1", int'(dut.r_tree[1]), int'(7'b001_0001));
    check("tree_set2", int'(dut.r_tree[2]), int'(7'b011_0010));

    // Flush in RUN with a concurrent request: request dropped, full sweep
    flush = 1'b1;
    req_valid = 1'b1; req_op = TOUCH; req_set = 4'd0; req_way = 3'd0;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    check("flush_rspvld", int'(rsp_valid), 0);
    wait_init(NS, "flush");
    check("flush_rspvld2", int'(rsp_valid), 0);

    // Flush during INIT restarts the sweep
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_init(NS, "reflush");
    for (int s = 0; s < NS; s++) issue(QUERY, s, 0, 7, $sformatf("clr%0d", s));

    // Randomised traffic against the reference model
    m_clear();
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      int s, w, e;
      op = 2'($urandom_range(0, 3));
      s  = $urandom_range(0, NS - 1);
      w  = $urandom_range(0, NW - 1);
      if ($urandom_range(0, 3) == 0) s = 5;
      e  = m_apply(op, s, w);
      issue(op, s, w, e, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        check("rnd_idle", int'(rsp_valid), 0);
      end
    end
    for (int s = 0; s < NS; s++) issue(QUERY, s, 0, m_victim(s), $sformatf("fin%0d", s));

    // Reset asserted the cycle after an accept: response dropped, INIT reruns
    req_valid = 1'b1; req_op = TOUCH; req_set = 4'd9; req_way = 3'd7;
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_rspvld", int'(rsp_valid), 0);
    check("rstmid_busy", int'({busy, req_ready}), 2);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(NS, "rstmid");
    check("rstmid_rspvld2", int'(rsp_valid), 0);
    issue(QUERY, 9, 0, 7, "rstmid_q9");
    issue(QUERY, 5, 0, 7, "rstmid_q5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
